// File: rtl/route_cmd_ctrl.sv
// rtl/route_cmd_ctrl.sv - follower route controller: destination queue, move/dwell sequencing, obstacle buzzer
module route_cmd_ctrl #(
    parameter int ID_W        = 6,
    parameter int DEPTH       = 4,
    parameter int BUZZ_PERIOD = 12500,
    parameter int DWELL_CYC   = 1000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   cmd,
    input  logic                         cmd_rdy,
    output logic                         clr_cmd_rdy,
    input  logic [7:0]                   ID,
    input  logic                         ID_vld,
    output logic                         clr_ID_vld,
    input  logic                         OK2Move,
    output logic                         in_transit,
    output logic                         go,
    output logic                         dwell,
    output logic                         buzz,
    output logic                         buzz_n,
    output logic [$clog2(DEPTH+1)-1:0]   q_cnt,
    output logic                         ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(BUZZ_PERIOD);
    localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;

    localparam logic [BW-1:0] BUZZ_HALF  = BW'(BUZZ_PERIOD / 2);
    localparam logic [BW-1:0] BUZZ_LAST  = BW'(BUZZ_PERIOD - 1);
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYC - 1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MOVE  = 2'd1,
        S_DWELL = 2'd2
    } state_t;

    state_t state, nxt_state;

    logic [ID_W-1:0] mem [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [DW-1:0]   dwell_cnt;
    logic [BW-1:0]   buzz_cnt;
    logic            wait_flag, wait_nxt;

    logic [1:0]      op;
    logic [ID_W-1:0] dest;
    logic [ID_W-1:0] head;
    logic            is_stop, is_go, is_app;
    logic            full, match, buzz_en;
    logic            do_flush, do_load, do_push, do_pop, ovf_set;

    assign op      = cmd[7:6];
    assign dest    = cmd[ID_W-1:0];
    assign is_stop = cmd_rdy && (op == 2'b00);
    assign is_go   = cmd_rdy && (op == 2'b01);
    assign is_app  = cmd_rdy && (op == 2'b10);
    assign head    = mem[rd_ptr];
    assign full    = (q_cnt == CNT_FULL);
    // Full 8-bit compare: upper ID bits must be zero for a match.
    assign match   = ID_vld && (q_cnt != '0) && (ID == {{(8-ID_W){1'b0}}, head});

    assign go      = in_transit & OK2Move;
    assign dwell   = (state == S_DWELL);
    assign buzz_n  = ~buzz;
    assign buzz_en = in_transit & ~OK2Move;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            in_transit <= 1'b0;
            ovf        <= 1'b0;
            wait_flag  <= 1'b0;
        end else begin
            state      <= nxt_state;
            in_transit <= (nxt_state == S_MOVE);
            ovf        <= ovf_set;
            wait_flag  <= wait_nxt;
        end
    end

    always_comb begin
        nxt_state = state;
        case (state)
            S_IDLE: begin
                if (is_go || (is_app && !full))
                    nxt_state = S_MOVE;
            end
            S_MOVE: begin
                if (is_stop)
                    nxt_state = S_IDLE;
                else if (is_go)
                    nxt_state = S_MOVE;
                else if (match)
                    // A same-cycle APPEND keeps an entry queued, so dwell instead of stopping.
                    nxt_state = ((q_cnt == CNT_ONE) && !is_app) ? S_IDLE : S_DWELL;
            end
            S_DWELL: begin
                if (is_stop)
                    nxt_state = S_IDLE;
                else if (is_go || (dwell_cnt == '0))
                    nxt_state = S_MOVE;
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    always_comb begin
        clr_cmd_rdy = cmd_rdy;
        clr_ID_vld  = 1'b0;
        do_flush    = 1'b0;
        do_load     = 1'b0;
        do_push     = 1'b0;
        do_pop      = 1'b0;
        ovf_set     = 1'b0;
        wait_nxt    = 1'b0;
        if (is_stop) begin
            do_flush = 1'b1;
            if (state == S_MOVE)
                wait_nxt = wait_flag & ID_vld;
        end else if (is_go) begin
            do_flush = 1'b1;
            do_load  = 1'b1;
            if (state == S_MOVE)
                wait_nxt = wait_flag & ID_vld;
        end else begin
            if (state == S_MOVE) begin
                if (match) begin
                    clr_ID_vld = 1'b1;
                    do_pop     = 1'b1;
                end else if (ID_vld) begin
                    clr_ID_vld = wait_flag;
                    wait_nxt   = ~wait_flag;
                end
            end
            if (is_app) begin
                if (!full || do_pop)
                    do_push = 1'b1;
                else
                    ovf_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            q_cnt  <= '0;
        end else if (do_flush) begin
            rd_ptr <= '0;
            wr_ptr <= do_load ? PW'(1) : '0;
            q_cnt  <= do_load ? CNT_ONE : '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   q_cnt <= q_cnt + CNT_ONE;
                2'b01:   q_cnt <= q_cnt - CNT_ONE;
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_load)
            mem[{PW{1'b0}}] <= dest;
        else if (do_push)
            mem[wr_ptr] <= dest;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dwell_cnt <= '0;
        else if ((nxt_state == S_DWELL) && (state != S_DWELL))
            dwell_cnt <= DWELL_LOAD;
        else if ((state == S_DWELL) && (dwell_cnt != '0))
            dwell_cnt <= dwell_cnt - DW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buzz_cnt <= '0;
            buzz     <= 1'b0;
        end else if (!buzz_en) begin
            buzz_cnt <= '0;
            buzz     <= 1'b0;
        end else begin
            buzz     <= (buzz_cnt < BUZZ_HALF);
            buzz_cnt <= (buzz_cnt == BUZZ_LAST) ? '0 : buzz_cnt + BW'(1);
        end
    end

endmodule

// File: tb/tb_route_cmd_ctrl.sv
// tb/tb_route_cmd_ctrl.sv - scoreboard bench for route_cmd_ctrl against a queue-based reference model
module tb_route_cmd_ctrl;

    localparam int ID_W  = 6;
    localparam int DEPTH = 4;
    localparam int BP    = 8;
    localparam int DWC   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cmd, ID;
    logic       cmd_rdy, ID_vld, OK2Move;
    logic       clr_cmd_rdy, clr_ID_vld, in_transit, go, dwell, buzz, buzz_n, ovf;
    logic [2:0] q_cnt;

    route_cmd_ctrl #(.ID_W(ID_W), .DEPTH(DEPTH), .BUZZ_PERIOD(BP), .DWELL_CYC(DWC)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .ID(ID), .ID_vld(ID_vld), .clr_ID_vld(clr_ID_vld), .OK2Move(OK2Move),
        .in_transit(in_transit), .go(go), .dwell(dwell), .buzz(buzz), .buzz_n(buzz_n),
        .q_cnt(q_cnt), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit clr_cmd, clr_id, go, in_transit, dwell, buzz, ovf;
        int qc;
    } exp_t;
    exp_t expq[$];

    typedef enum {M_IDLE, M_MOVE, M_DWELL} mst_t;
    mst_t ms;
    int   mq[$];
    int   dwell_left, bphase;
    bit   mwait, movf, mbuzz;
    bit   last_clr_id;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ms = M_IDLE; mq.delete(); dwell_left = 0; bphase = 0;
        mwait = 0; movf = 0; mbuzz = 0;
    endtask

    // One clock: drive inputs, predict this cycle's outputs, advance the model.
    task automatic step(input bit crdy, input logic [7:0] c, input bit ivld,
                        input logic [7:0] id, input bit ok);
        exp_t e;
        mst_t st0;
        bit   stopgo, hit, nwait;
        int   op, dst;
        cmd_rdy = crdy; cmd = c; ID_vld = ivld; ID = id; OK2Move = ok;
        op     = int'(c[7:6]);
        dst    = int'(c[5:0]);
        st0    = ms;
        stopgo = crdy && (op == 0 || op == 1);
        hit    = ivld && (mq.size() > 0) && (int'(id) == mq[0]);

        e.clr_cmd    = crdy;
        e.clr_id     = (st0 == M_MOVE) && !stopgo && ivld && (hit || mwait);
        e.go         = (st0 == M_MOVE) && ok;
        e.in_transit = (st0 == M_MOVE);
        e.dwell      = (st0 == M_DWELL);
        e.buzz       = mbuzz;
        e.ovf        = movf;
        e.qc         = mq.size();
        expq.push_back(e);
        last_clr_id  = e.clr_id;

        if (st0 == M_MOVE && !ok) begin
            mbuzz  = (bphase < BP / 2);
            bphase = (bphase + 1) % BP;
        end else begin
            mbuzz  = 0;
            bphase = 0;
        end
        nwait = 0;
        if (st0 == M_MOVE && ivld)
            nwait = stopgo ? mwait : (!hit && !mwait);
        movf = 0;

        if (crdy && op == 0) begin
            mq.delete();
            ms = M_IDLE;
        end else if (crdy && op == 1) begin
            mq.delete();
            mq.push_back(dst);
            ms = M_MOVE;
        end else begin
            if (st0 == M_MOVE && hit)
                void'(mq.pop_front());
            if (crdy && op == 2) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(dst);
                    if (st0 == M_IDLE) ms = M_MOVE;
                end else begin
                    movf = 1;
                end
            end
            if (st0 == M_MOVE && hit) begin
                ms = (mq.size() == 0) ? M_IDLE : M_DWELL;
                dwell_left = DWC;
            end else if (st0 == M_DWELL) begin
                dwell_left--;
                if (dwell_left == 0) ms = M_MOVE;
            end
        end
        mwait = nwait;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit ok);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 8'h00, ok);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_transit"}, int'(in_transit), 0);
        chk({tag, "_go"},         int'(go), 0);
        chk({tag, "_dwell"},      int'(dwell), 0);
        chk({tag, "_buzz"},       int'(buzz), 0);
        chk({tag, "_buzz_n"},     int'(buzz_n), 1);
        chk({tag, "_ovf"},        int'(ovf), 0);
        chk({tag, "_q_cnt"},      int'(q_cnt), 0);
    endtask

    // Scoreboard monitor: one expectation per clock, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("clr_cmd_rdy", int'(clr_cmd_rdy), int'(e.clr_cmd));
                chk("clr_ID_vld",  int'(clr_ID_vld),  int'(e.clr_id));
                chk("go",          int'(go),          int'(e.go));
                chk("in_transit",  int'(in_transit),  int'(e.in_transit));
                chk("dwell",       int'(dwell),       int'(e.dwell));
                chk("buzz",        int'(buzz),        int'(e.buzz));
                chk("buzz_n",      int'(buzz_n),      int'(!e.buzz));
                chk("ovf",         int'(ovf),         int'(e.ovf));
                chk("q_cnt",       int'(q_cnt),       e.qc);
            end
        end
    end

    initial begin
        bit       ivld, ok, crdy;
        logic [7:0] id, c;
        int       r;
        rst = 1'b1; cmd = 8'h00; ID = 8'h00; cmd_rdy = 0; ID_vld = 0; OK2Move = 1;
        model_reset();
        @(posedge clk); #1;
        chk_reset_outputs("por");
        @(posedge clk); #1;
        rst = 1'b0;

        // GO to 5, then arrive at 5
        step(1, 8'h45, 0, 8'h00, 1);
        idle(2, 1);
        step(0, 8'h00, 1, 8'h05, 1);
        idle(1, 1);

        // APPEND 1,2,3 from IDLE, arrive at 1, dwell
        step(1, 8'h81, 0, 8'h00, 1);
        step(1, 8'h82, 0, 8'h00, 1);
        step(1, 8'h83, 0, 8'h00, 1);
        step(0, 8'h00, 1, 8'h01, 1);
        idle(6, 1);

        // wrong station held, and one with nonzero upper bits
        step(0, 8'h00, 1, 8'h07, 1);
        step(0, 8'h00, 1, 8'h07, 1);
        step(0, 8'h00, 0, 8'h00, 1);
        step(0, 8'h00, 1, 8'h42, 1);
        step(0, 8'h00, 1, 8'h42, 1);
        step(0, 8'h00, 0, 8'h00, 1);

        // fill to DEPTH, overflow drop, then STOP
        step(1, 8'h84, 0, 8'h00, 1);
        step(1, 8'h85, 0, 8'h00, 1);
        step(1, 8'h86, 0, 8'h00, 1);
        idle(2, 1);
        step(1, 8'h00, 0, 8'h00, 1);
        idle(1, 1);

        // buzzer while blocked, then released
        step(1, 8'h41, 0, 8'h00, 1);
        idle(20, 0);
        idle(3, 1);

        // GO collides with a matching ID; ID stays pending against new head
        step(1, 8'h43, 1, 8'h01, 1);
        step(0, 8'h00, 1, 8'h01, 1);
        step(0, 8'h00, 1, 8'h01, 1);
        step(0, 8'h00, 1, 8'h03, 1);
        idle(1, 1);

        // APPEND coinciding with the last pop goes to DWELL
        step(1, 8'h42, 0, 8'h00, 1);
        step(1, 8'h84, 1, 8'h02, 1);
        idle(6, 1);

        // reset in DWELL
        step(1, 8'h81, 0, 8'h00, 1);
        step(1, 8'h82, 0, 8'h00, 1);
        step(0, 8'h00, 1, 8'h01, 1);
        step(0, 8'h00, 0, 8'h00, 1);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        idle(2, 1);

        // randomized traffic
        ivld = 0; id = 8'h00; ok = 1;
        for (int i = 0; i < 3000; i++) begin
            crdy = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 15);
            c[7:6] = (r < 2) ? 2'b00 : (r < 5) ? 2'b01 : (r < 14) ? 2'b10 : 2'b11;
            c[5:0] = 6'($urandom_range(0, 7));
            if (ivld && (last_clr_id || $urandom_range(0, 9) == 0)) begin
                ivld = 0;
            end else if (!ivld && $urandom_range(0, 3) == 0) begin
                ivld = 1;
                r = $urandom_range(0, 3);
                if (r < 2 && mq.size() > 0) id = 8'(mq[0]);
                else if (r == 3)            id = 8'h40 | 8'($urandom_range(0, 7));
                else                        id = 8'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 9) == 0) ok = !ok;
            step(crdy, c, ivld, id, ok);
        end
        idle(1, 1);

        @(negedge clk);
        chk("scoreboard_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
